// File: rtl/sram_banked_spw_if.sv
// Request/response bus for sram_banked_spw.
//   master : drives req_valid/req_we/req_addr/req_wdata/req_be,
//            observes req_ready, rsp_valid, rsp_rdata
//   slave  : the memory side of the same signals
interface sram_banked_spw_if #(
   parameter int DW = 16,
   parameter int AW = 11
);
   localparam int NBE = DW / 8;

   logic           req_valid;
   logic           req_ready;
   logic           req_we;
   logic [AW-1:0]  req_addr;
   logic [DW-1:0]  req_wdata;
   logic [NBE-1:0] req_be;
   logic           rsp_valid;
   logic [DW-1:0]  rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_banked_spw.sv
// Banked single-port word memory with byte enables and hardware clear.
// After reset every bank is zeroed in parallel, one row per cycle, then the
// block accepts one request per cycle. Reads answer one cycle later.
//   clk       : clock, all state on rising edge
//   rst       : synchronous active-high reset
//   bus       : request/response bus (slave side)
//   init_done : memory clear complete
module sram_banked_spw #(
   parameter int DW    = 16,
   parameter int DEPTH = 2048,
   parameter int NBANK = 2
) (
   input  logic              clk,
   input  logic              rst,
   sram_banked_spw_if.slave  bus,
   output logic              init_done
);
   localparam int AW     = $clog2(DEPTH);
   localparam int BKW    = $clog2(NBANK);
   localparam int BDEPTH = DEPTH / NBANK;
   localparam int NBE    = DW / 8;
   localparam int RW     = AW - BKW;
   localparam int BSW    = (BKW == 0) ? 1 : BKW;
   localparam int RWW    = (RW == 0) ? 1 : RW;

   if (DW < 8 || (DW % 8) != 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       NBANK < 1 || (NBANK & (NBANK - 1)) != 0 || NBANK > DEPTH) begin : g_bad_params
      $error("sram_banked_spw: illegal parameter set");
   end

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [RWW-1:0]   r_cnt;
   logic             w_last;
   logic             w_ready;
   logic             w_init_done;
   logic             w_acc;
   logic [BSW-1:0]   w_bank;
   logic [RWW-1:0]   w_row;
   logic [BSW-1:0]   r_sel;
   logic             r_rsp_valid;
   logic [DW-1:0]    w_bank_q [NBANK];

   assign w_last = (r_cnt == RWW'(BDEPTH - 1));

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + RWW'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_init_done = 1'b0;
      case (r_state)
         ST_INIT: begin
            if (w_last) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_ready     = 1'b1;
            w_init_done = 1'b1;
         end
         default: w_state_nxt = ST_INIT;
      endcase
   end

   assign bus.req_ready = w_ready;
   assign init_done     = w_init_done;
   assign w_acc         = bus.req_valid && w_ready;

   // ---------------- address split ----------------
   if (BKW == 0) begin : g_bank_one
      assign w_bank = '0;
   end else begin : g_bank_sel
      assign w_bank = bus.req_addr[AW-1 -: BKW];
   end

   if (RW == 0) begin : g_row_none
      assign w_row = '0;
   end else begin : g_row_sel
      assign w_row = bus.req_addr[RW-1:0];
   end

   // ---------------- banks ----------------
   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      logic [DW-1:0] r_mem [BDEPTH];
      logic [DW-1:0] r_q;
      logic          w_en;

      assign w_en = w_acc && (w_bank == BSW'(b));

      // Clear has priority over requests, but requests cannot be accepted in INIT anyway.
      always_ff @(posedge clk) begin
         if (!rst) begin
            if (r_state == ST_INIT) begin
               r_mem[r_cnt] <= '0;
            end else if (w_en && bus.req_we) begin
               for (int unsigned i = 0; i < NBE; i++) begin
                  if (bus.req_be[i]) begin
                     r_mem[w_row][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                  end
               end
            end
         end
      end

      // Output register only moves on a read of this bank, so the muxed
      // response holds its value between reads.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_q <= '0;
         end else if (w_en && !bus.req_we) begin
            r_q <= r_mem[w_row];
         end
      end

      assign w_bank_q[b] = r_q;
   end

   // ---------------- response ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_sel       <= '0;
      end else begin
         r_rsp_valid <= w_acc && !bus.req_we;
         if (w_acc && !bus.req_we) begin
            r_sel <= w_bank;
         end
      end
   end

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = w_bank_q[r_sel];
endmodule

// File: tb/tb_sram_banked_spw.sv
// Directed bench for sram_banked_spw: default 2-bank build plus a 4-bank,
// 1024-word build. Inputs driven on the falling edge, outputs sampled on
// the falling edge after the capturing rising edge.
module tb_sram_banked_spw;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0 = 1'b1;
   logic rst1 = 1'b1;
   logic init0;
   logic init1;
   int   total = 0;
   int   bad   = 0;

   sram_banked_spw_if #(.DW(16), .AW(11)) if0 ();
   sram_banked_spw_if #(.DW(16), .AW(10)) if1 ();

   sram_banked_spw #(.DW(16), .DEPTH(2048), .NBANK(2)) dut0 (
      .clk       (clk),
      .rst       (rst0),
      .bus       (if0),
      .init_done (init0)
   );

   sram_banked_spw #(.DW(16), .DEPTH(1024), .NBANK(4)) dut1 (
      .clk       (clk),
      .rst       (rst1),
      .bus       (if1),
      .init_done (init1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic get_ready(input int s);
      return (s == 0) ? if0.req_ready : if1.req_ready;
   endfunction

   function automatic logic get_init(input int s);
      return (s == 0) ? init0 : init1;
   endfunction

   function automatic logic get_rv(input int s);
      return (s == 0) ? if0.rsp_valid : if1.rsp_valid;
   endfunction

   function automatic logic [15:0] get_rd(input int s);
      return (s == 0) ? if0.rsp_rdata : if1.rsp_rdata;
   endfunction

   task automatic drive(input int s, input logic v, input logic we, input logic [10:0] a,
                        input logic [15:0] d, input logic [1:0] be);
      if (s == 0) begin
         if0.req_valid = v;
         if0.req_we    = we;
         if0.req_addr  = a;
         if0.req_wdata = d;
         if0.req_be    = be;
      end else begin
         if1.req_valid = v;
         if1.req_we    = we;
         if1.req_addr  = a[9:0];
         if1.req_wdata = d;
         if1.req_be    = be;
      end
   endtask

   task automatic idle(input int s);
      drive(s, 1'b0, 1'b0, 11'h0, 16'h0, 2'b00);
   endtask

   task automatic wr(input int s, input logic [10:0] a, input logic [15:0] d, input logic [1:0] be);
      drive(s, 1'b1, 1'b1, a, d, be);
      @(negedge clk);
      idle(s);
   endtask

   task automatic rd(input int s, input logic [10:0] a, input logic [15:0] exp, input string tag);
      drive(s, 1'b1, 1'b0, a, 16'h0, 2'b00);
      @(negedge clk);
      idle(s);
      check({tag, "_v"}, 32'(get_rv(s)), 32'd1);
      check(tag, 32'(get_rd(s)), 32'(exp));
   endtask

   // Counts falling edges after rst release until req_ready rises (bounded).
   task automatic wait_init(input int s, input int exp_cycles, input string tag);
      int n = 0;
      bit done = 1'b0;
      while (!done && n < 5000) begin
         @(negedge clk);
         n++;
         if (get_ready(s)) done = 1'b1;
      end
      check({tag, "_len"}, 32'(n), 32'(exp_cycles));
      check({tag, "_done"}, 32'(get_init(s)), 32'd1);
   endtask

   initial begin
      idle(0);
      idle(1);
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(if0.req_ready), 32'd0);
      check("rst_init", 32'(init0), 32'd0);
      check("rst_rv", 32'(if0.rsp_valid), 32'd0);
      check("rst_rdata", 32'(if0.rsp_rdata), 32'd0);

      // A write held valid through INIT must be ignored.
      drive(0, 1'b1, 1'b1, 11'h005, 16'hFFFF, 2'b11);
      rst0 = 1'b0;
      wait_init(0, 1024, "init0");
      idle(0);
      check("init_no_rsp", 32'(if0.rsp_valid), 32'd0);

      rd(0, 11'h000, 16'h0000, "rd_000");
      rd(0, 11'h7FF, 16'h0000, "rd_7ff");
      rd(0, 11'h005, 16'h0000, "init_drop");

      wr(0, 11'h400, 16'hA5A5, 2'b11);
      rd(0, 11'h400, 16'hA5A5, "rd_400");
      rd(0, 11'h000, 16'h0000, "iso_000");

      wr(0, 11'h123, 16'h1234, 2'b11);
      wr(0, 11'h123, 16'hABCD, 2'b01);
      rd(0, 11'h123, 16'h12CD, "be_lo");
      wr(0, 11'h123, 16'hFFFF, 2'b00);
      rd(0, 11'h123, 16'h12CD, "be_none");

      wr(0, 11'h001, 16'h1111, 2'b11);
      wr(0, 11'h401, 16'h2222, 2'b11);
      drive(0, 1'b1, 1'b0, 11'h001, 16'h0, 2'b00);
      @(negedge clk);
      check("b2b0_v", 32'(if0.rsp_valid), 32'd1);
      check("b2b0", 32'(if0.rsp_rdata), 32'h1111);
      drive(0, 1'b1, 1'b0, 11'h401, 16'h0, 2'b00);
      @(negedge clk);
      check("b2b1_v", 32'(if0.rsp_valid), 32'd1);
      check("b2b1", 32'(if0.rsp_rdata), 32'h2222);
      drive(0, 1'b1, 1'b0, 11'h001, 16'h0, 2'b00);
      @(negedge clk);
      check("b2b2_v", 32'(if0.rsp_valid), 32'd1);
      check("b2b2", 32'(if0.rsp_rdata), 32'h1111);
      idle(0);
      @(negedge clk);
      check("hold_v", 32'(if0.rsp_valid), 32'd0);
      check("hold_data", 32'(if0.rsp_rdata), 32'h1111);

      wr(0, 11'h002, 16'h3C3C, 2'b11);
      rd(0, 11'h002, 16'h3C3C, "raw_next");

      // Read presented in the reset cycle: its response must be dropped.
      drive(0, 1'b1, 1'b0, 11'h400, 16'h0, 2'b00);
      rst0 = 1'b1;
      @(negedge clk);
      idle(0);
      check("rst2_rv", 32'(if0.rsp_valid), 32'd0);
      check("rst2_ready", 32'(if0.req_ready), 32'd0);
      check("rst2_init", 32'(init0), 32'd0);
      check("rst2_rdata", 32'(if0.rsp_rdata), 32'd0);
      rst0 = 1'b0;
      wait_init(0, 1024, "init0b");
      rd(0, 11'h400, 16'h0000, "reclr_400");
      rd(0, 11'h123, 16'h0000, "reclr_123");

      rst1 = 1'b0;
      wait_init(1, 256, "init1");
      wr(1, 11'h3FF, 16'hBEEF, 2'b11);
      rd(1, 11'h3FF, 16'hBEEF, "nb4_3ff");
      rd(1, 11'h0FF, 16'h0000, "nb4_0ff");
      rd(1, 11'h2FF, 16'h0000, "nb4_2ff");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
